// File: rtl/mode_ctrl_pkg.sv
// Shared mode encodings and sequencer state for mode_ctrl and the mode-banked
// consumers: the flag file and the decode stage.
package mode_ctrl_pkg;

  localparam int NUM_IRQ_DEF = 4;
  localparam int PC_W_DEF    = 16;

  localparam logic [1:0] MODE_BOOT = 2'b00;
  localparam logic [1:0] MODE_USER = 2'b01;
  localparam logic [1:0] MODE_INTR = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_USER  = 3'd1,
    ST_ENTER = 3'd2,
    ST_INTR  = 3'd3,
    ST_EXIT  = 3'd4
  } state_t;

endpackage

// File: rtl/mode_ctrl_if.sv
// Bus between mode_ctrl, the interrupt sources and the fetch/PC stage.
// slave is the sequencer's view. master is the environment's view.
interface mode_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 16
);
  logic               boot_done;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               stall;
  logic [PC_W-1:0]    pc_in;
  logic               rti;
  logic [1:0]         Mode;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [PC_W-1:0]    epc;
  logic [NUM_IRQ-1:0] pending;

  modport slave (
    input  boot_done, irq, irq_mask, stall, pc_in, rti,
    output Mode, redirect, redirect_pc, irq_ack, epc, pending
  );

  modport master (
    output boot_done, irq, irq_mask, stall, pc_in, rti,
    input  Mode, redirect, redirect_pc, irq_ack, epc, pending
  );
endinterface

// File: rtl/mode_ctrl_irq_prio_enc.sv
// Lowest-index-wins priority encoder: (pending & mask) -> {valid, index}.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [N-1:0] act;

  assign act   = req & mask;
  assign valid = |act;

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (act[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/mode_ctrl.sv
// Processor mode sequencer: BOOT/USER/INTR lifecycle, single-level interrupt
// entry and RTI return. Every output is registered.
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ    = NUM_IRQ_DEF,
  parameter int          PC_W       = PC_W_DEF,
  parameter int unsigned VEC_BASE   = 16'h0010,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  mode_ctrl_if.slave  bus
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t             state;
  logic [1:0]         mode_q;
  logic               redirect_q;
  logic [PC_W-1:0]    redirect_pc_q;
  logic [NUM_IRQ-1:0] ack_q;
  logic [PC_W-1:0]    epc_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] irq_q;

  logic [NUM_IRQ-1:0] rise;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [PC_W-1:0]    vec_pc;

  irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
    .req   (pending_q),
    .mask  (bus.irq_mask),
    .valid (sel_vld),
    .idx   (sel)
  );

  assign rise   = bus.irq & ~irq_q;
  assign sel_oh = NUM_IRQ'(1) << sel;
  assign vec_pc = PC_W'(VEC_BASE) + PC_W'(VEC_STRIDE) * PC_W'(sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BOOT;
      mode_q        <= MODE_BOOT;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      ack_q         <= '0;
      epc_q         <= '0;
      pending_q     <= '0;
      irq_q         <= '0;
    end else begin
      irq_q      <= bus.irq;
      redirect_q <= 1'b0;
      ack_q      <= '0;
      // A fresh edge is OR'd in after any clear, so a set beats a same-cycle clear.
      pending_q  <= pending_q | rise;
      case (state)
        ST_BOOT: begin
          pending_q <= '0;
          if (bus.boot_done) begin
            state  <= ST_USER;
            mode_q <= MODE_USER;
          end
        end
        ST_USER: begin
          if (sel_vld && !bus.stall) begin
            state         <= ST_ENTER;
            mode_q        <= MODE_INTR;
            epc_q         <= bus.pc_in;
            pending_q     <= (pending_q & ~sel_oh) | rise;
            redirect_q    <= 1'b1;
            redirect_pc_q <= vec_pc;
            ack_q         <= sel_oh;
          end
        end
        ST_ENTER: state <= ST_INTR;
        ST_INTR: begin
          if (bus.rti && !bus.stall) begin
            state         <= ST_EXIT;
            redirect_q    <= 1'b1;
            redirect_pc_q <= epc_q;
          end
        end
        ST_EXIT: begin
          state  <= ST_USER;
          mode_q <= MODE_USER;
        end
        default: begin
          state  <= ST_BOOT;
          mode_q <= MODE_BOOT;
        end
      endcase
    end
  end

  assign bus.Mode        = mode_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.irq_ack     = ack_q;
  assign bus.epc         = epc_q;
  assign bus.pending     = pending_q;
endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl: boot, entry/return, priority, no-nesting,
// masking, stall and mid-redirect reset.
module tb_mode_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  mode_ctrl_if #(.NUM_IRQ(4), .PC_W(16)) bus ();

  mode_ctrl #(.NUM_IRQ(4), .PC_W(16), .VEC_BASE(16'h0010), .VEC_STRIDE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ENTER -> INTR -> EXIT -> USER with no checking.
  task automatic finish_isr();
    bus.irq = '0;
    step();
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.boot_done = 0; bus.irq = '0; bus.irq_mask = 4'hF;
    bus.stall = 0; bus.pc_in = '0; bus.rti = 0;
    step(); step();
    rst = 1'b0;
    checks++; if (bus.Mode !== 2'b00) begin failures++; $display("FAIL reset_mode got=%b exp=00", bus.Mode); end
    checks++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 16'h0) begin failures++; $display("FAIL reset_redirect got=%b/%h exp=0/0000", bus.redirect, bus.redirect_pc); end
    checks++; if (bus.irq_ack !== 4'h0 || bus.epc !== 16'h0 || bus.pending !== 4'h0) begin failures++; $display("FAIL reset_misc ack=%b epc=%h pend=%b exp=0", bus.irq_ack, bus.epc, bus.pending); end
    bus.boot_done = 1'b1;
    step();
    bus.boot_done = 1'b0;
    checks++; if (bus.Mode !== 2'b01) begin failures++; $display("FAIL boot_to_user got=%b exp=01", bus.Mode); end
    checks++; if (bus.redirect !== 1'b0 || bus.pending !== 4'h0) begin failures++; $display("FAIL boot_outputs redirect=%b pend=%b exp=0/0000", bus.redirect, bus.pending); end
  endtask

  task automatic test_single();
    bus.pc_in = 16'h0123; bus.irq = 4'b0100;
    step();
    checks++; if (bus.pending !== 4'b0100 || bus.Mode !== 2'b01) begin failures++; $display("FAIL single_capture pend=%b mode=%b exp=0100/01", bus.pending, bus.Mode); end
    step();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0018) begin failures++; $display("FAIL single_enter redirect=%b pc=%h exp=1/0018", bus.redirect, bus.redirect_pc); end
    checks++; if (bus.irq_ack !== 4'b0100 || bus.epc !== 16'h0123 || bus.Mode !== 2'b10) begin failures++; $display("FAIL single_enter_misc ack=%b epc=%h mode=%b exp=0100/0123/10", bus.irq_ack, bus.epc, bus.Mode); end
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL single_pend_clear got=%b exp=0000", bus.pending); end
    bus.irq = '0;
    step();
    checks++; if (bus.redirect !== 1'b0 || bus.irq_ack !== 4'h0 || bus.Mode !== 2'b10) begin failures++; $display("FAIL single_intr redirect=%b ack=%b mode=%b exp=0/0000/10", bus.redirect, bus.irq_ack, bus.Mode); end
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0123 || bus.Mode !== 2'b10) begin failures++; $display("FAIL single_exit redirect=%b pc=%h mode=%b exp=1/0123/10", bus.redirect, bus.redirect_pc, bus.Mode); end
    step();
    checks++; if (bus.Mode !== 2'b01 || bus.redirect !== 1'b0) begin failures++; $display("FAIL single_user mode=%b redirect=%b exp=01/0", bus.Mode, bus.redirect); end
  endtask

  task automatic test_priority();
    bus.pc_in = 16'h0200; bus.irq = 4'b1010;
    step(); step();
    checks++; if (bus.redirect_pc !== 16'h0014 || bus.irq_ack !== 4'b0010) begin failures++; $display("FAIL prio_first pc=%h ack=%b exp=0014/0010", bus.redirect_pc, bus.irq_ack); end
    checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL prio_pend got=%b exp=1000", bus.pending); end
    bus.irq = '0;
    step();
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.redirect_pc !== 16'h0200 || bus.redirect !== 1'b1) begin failures++; $display("FAIL prio_exit pc=%h redirect=%b exp=0200/1", bus.redirect_pc, bus.redirect); end
    step();
    checks++; if (bus.Mode !== 2'b01) begin failures++; $display("FAIL prio_user got=%b exp=01", bus.Mode); end
    step();
    checks++; if (bus.redirect_pc !== 16'h001C || bus.irq_ack !== 4'b1000 || bus.redirect !== 1'b1) begin failures++; $display("FAIL prio_second pc=%h ack=%b exp=001C/1000", bus.redirect_pc, bus.irq_ack); end
    finish_isr();
  endtask

  task automatic test_no_nesting();
    bus.pc_in = 16'h0300; bus.irq = 4'b0100;
    step(); step();
    bus.irq = '0;
    step();
    bus.irq = 4'b0001;
    step();
    checks++; if (bus.pending !== 4'b0001 || bus.redirect !== 1'b0 || bus.Mode !== 2'b10) begin failures++; $display("FAIL nest_hold pend=%b redirect=%b mode=%b exp=0001/0/10", bus.pending, bus.redirect, bus.Mode); end
    bus.irq = '0;
    step();
    checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL nest_idle redirect=%b exp=0", bus.redirect); end
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0300) begin failures++; $display("FAIL nest_exit redirect=%b pc=%h exp=1/0300", bus.redirect, bus.redirect_pc); end
    step();
    checks++; if (bus.Mode !== 2'b01 || bus.redirect !== 1'b0) begin failures++; $display("FAIL nest_user mode=%b redirect=%b exp=01/0", bus.Mode, bus.redirect); end
    step();
    checks++; if (bus.redirect_pc !== 16'h0010 || bus.irq_ack !== 4'b0001) begin failures++; $display("FAIL nest_enter0 pc=%h ack=%b exp=0010/0001", bus.redirect_pc, bus.irq_ack); end
    finish_isr();
  endtask

  task automatic test_mask_stall();
    bus.irq_mask = 4'b1110; bus.irq = 4'b0001;
    step();
    bus.irq = '0;
    step(); step();
    checks++; if (bus.Mode !== 2'b01 || bus.redirect !== 1'b0 || bus.pending !== 4'b0001) begin failures++; $display("FAIL mask_hold mode=%b redirect=%b pend=%b exp=01/0/0001", bus.Mode, bus.redirect, bus.pending); end
    bus.irq_mask = 4'hF;
    step();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0010) begin failures++; $display("FAIL mask_release redirect=%b pc=%h exp=1/0010", bus.redirect, bus.redirect_pc); end
    finish_isr();
    bus.stall = 1'b1; bus.pc_in = 16'h0400; bus.irq = 4'b0100;
    step(); step(); step();
    checks++; if (bus.Mode !== 2'b01 || bus.redirect !== 1'b0 || bus.pending !== 4'b0100) begin failures++; $display("FAIL stall_hold mode=%b redirect=%b pend=%b exp=01/0/0100", bus.Mode, bus.redirect, bus.pending); end
    checks++; if (bus.epc !== 16'h0300) begin failures++; $display("FAIL stall_epc got=%h exp=0300", bus.epc); end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0018 || bus.epc !== 16'h0400) begin failures++; $display("FAIL stall_release redirect=%b pc=%h epc=%h exp=1/0018/0400", bus.redirect, bus.redirect_pc, bus.epc); end
    finish_isr();
  endtask

  task automatic test_back_to_back();
    // Line 2 re-rises on the very edge that selects it: the bit stays set.
    bus.stall = 1'b1; bus.irq = 4'b0100;
    step();
    bus.irq = '0;
    step();
    bus.irq = 4'b0100; bus.stall = 1'b0;
    step();
    checks++; if (bus.redirect !== 1'b1 || bus.pending !== 4'b0100) begin failures++; $display("FAIL set_wins redirect=%b pend=%b exp=1/0100", bus.redirect, bus.pending); end
    finish_isr();
    step();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0018 || bus.pending !== 4'b0000) begin failures++; $display("FAIL b2b_enter redirect=%b pc=%h pend=%b exp=1/0018/0000", bus.redirect, bus.redirect_pc, bus.pending); end
    finish_isr();
  endtask

  task automatic test_reset_mid();
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.Mode !== 2'b01 || bus.redirect !== 1'b0) begin failures++; $display("FAIL rti_user mode=%b redirect=%b exp=01/0", bus.Mode, bus.redirect); end
    bus.irq = 4'b0010;
    step(); step();
    checks++; if (bus.redirect !== 1'b1) begin failures++; $display("FAIL pre_reset_enter redirect=%b exp=1", bus.redirect); end
    rst = 1'b1; bus.irq = '0;
    step();
    rst = 1'b0;
    checks++; if (bus.Mode !== 2'b00 || bus.redirect !== 1'b0 || bus.pending !== 4'h0 || bus.epc !== 16'h0) begin failures++; $display("FAIL mid_reset mode=%b redirect=%b pend=%b epc=%h exp=00/0/0000/0000", bus.Mode, bus.redirect, bus.pending, bus.epc); end
    bus.irq = 4'b0100;
    step();
    checks++; if (bus.Mode !== 2'b00 || bus.pending !== 4'h0) begin failures++; $display("FAIL boot_ignore mode=%b pend=%b exp=00/0000", bus.Mode, bus.pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_nesting();
    test_mask_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
